// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider.
//   start     : single-cycle request, sampled on the rising clock edge
//   dividend  : unsigned dividend, valid with start
//   divisor   : unsigned divisor, valid with start
//   quotient  : registered quotient, valid while finish is high
//   remainder : registered remainder, valid while finish is high
//   finish    : one-cycle completion pulse
// master drives the request, slave (the divider) drives the result.
interface seq_divider_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             finish;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  finish
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output finish
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
// A request accepted in IDLE completes in exactly WIDTH cycles regardless of
// operand values; finish then pulses for one cycle. Divide by zero yields an
// all-ones quotient and remainder = dividend, with no special handling.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if slave (start/dividend/divisor in,
//           quotient/remainder/finish out)
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
    // after WIDTH steps this register holds the full quotient.
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             finish_q, finish_d;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            finish_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            finish_q    <= finish_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        finish_d    = 1'b0;

        // Partial remainder needs one extra bit after the shift, before the
        // trial subtraction brings it back below the divisor.
        shifted = {rem_q, dq_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        // When fits is set the true difference is < 2^WIDTH, so dropping the
        // top bit of the subtraction is exact.
        diff    = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dq_d    = bus.dividend;
                    dvs_d   = bus.divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rem_d = diff;
                dq_d  = {dq_q[WIDTH-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quotient_d  = {dq_q[WIDTH-2:0], fits};
                    remainder_d = diff;
                    finish_d    = 1'b1;
                    cnt_d       = '0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.finish    = finish_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH = 8). Each request pushes its
// expected quotient, remainder and finish cycle into a scoreboard; a monitor
// pops and compares on every finish pulse.
module tb_seq_divider;
    localparam int WIDTH = 8;

    typedef struct {
        int q;
        int r;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cycle;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: every finish pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.finish === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(bus.quotient), e.q);
                check("remainder", int'(bus.remainder), e.r);
                check("finish_cycle", cycle, e.cyc);
            end
        end
    end

    // Drive a one-cycle request from a negedge; the accepting edge is the next
    // posedge, and finish is seen WIDTH edges after that.
    task automatic issue(input int a, input int b, input int q, input int r);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a[WIDTH-1:0];
        bus.divisor  = b[WIDTH-1:0];
        e.q   = q;
        e.r   = r;
        e.cyc = cycle + 1 + WIDTH;
        sb.push_back(e);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        cycle        = 0;
        n_assert     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (3) @(negedge clk);
        check("reset_quotient", int'(bus.quotient), 0);
        check("reset_remainder", int'(bus.remainder), 0);
        check("reset_finish", int'(bus.finish), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic operation and operand corners.
        issue(34, 12, 2, 10);
        drain(20);
        issue(255, 1, 255, 0);
        drain(20);
        issue(7, 9, 0, 7);
        drain(20);
        issue(0, 5, 0, 0);
        drain(20);
        issue(255, 255, 1, 0);
        drain(20);
        issue(100, 0, 255, 100);
        drain(20);

        // A start during CALC must be ignored.
        issue(34, 12, 2, 10);
        repeat (3) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd7;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        drain(20);
        issue(50, 7, 7, 1);
        drain(20);

        // start held high: accepts at n+1, n+11, n+21; dropped before n+31.
        @(negedge clk);
        begin
            int n0;
            n0 = cycle;
            bus.start    = 1'b1;
            bus.dividend = 8'd200;
            bus.divisor  = 8'd3;
            for (int k = 0; k < 3; k++) begin
                exp_t e;
                e.q   = 66;
                e.r   = 2;
                e.cyc = n0 + 1 + WIDTH + k * (WIDTH + 2);
                sb.push_back(e);
            end
            while (cycle < n0 + 25) @(negedge clk);
            bus.start    = 1'b0;
            bus.dividend = '0;
            bus.divisor  = '0;
        end
        drain(40);
        repeat (15) @(negedge clk);

        // Reset mid-CALC: outputs clear at once and no finish follows.
        issue(34, 12, 2, 10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        check("abort_finish", int'(bus.finish), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_quotient_held", int'(bus.quotient), 0);
        issue(34, 12, 2, 10);
        drain(20);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
